// File: rtl/pad_cfg_sequencer_if.sv
// Register bus between the SoC control fabric and the pad configuration sequencer.
// Reads complete the cycle after acceptance; writes are held off while a commit runs.
interface pad_cfg_sequencer_if;
    logic        reg_valid;
    logic        reg_ready;
    logic        reg_write;
    logic [7:0]  reg_addr;
    logic [31:0] reg_wdata;
    logic        reg_rvalid;
    logic [31:0] reg_rdata;

    modport master (
        output reg_valid, reg_write, reg_addr, reg_wdata,
        input  reg_ready, reg_rvalid, reg_rdata
    );

    modport slave (
        input  reg_valid, reg_write, reg_addr, reg_wdata,
        output reg_ready, reg_rvalid, reg_rdata
    );
endinterface

// File: rtl/pad_cfg_sequencer.sv
// Shadow-register pad configuration controller: applies ie/oen/tech-config to the four
// padring sides one at a time, never changing config while a side's pins are enabled.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// S_IDLE    | waiting for a commit request, bus fully open
// S_QUIESCE | current side: drivers off (oen all 1), inputs off (ie 0)
// S_APPLY   | current side: load shadow tech config, start settle timer
// S_WAIT    | settle timer counting down to zero
// S_RELEASE | current side: apply shadow ie/oen, then next side or finish
module pad_cfg_sequencer #(
    parameter int NPINS  = 9,
    parameter int CFGW   = 18,
    parameter int SETTLE = 16
) (
    input  logic                    clk,
    input  logic                    nreset,
    pad_cfg_sequencer_if.slave      bus,
    output logic [4*NPINS-1:0]      pad_ie,
    output logic [4*NPINS-1:0]      pad_oen,
    output logic [4*NPINS*CFGW-1:0] pad_cfg,
    output logic                    busy,
    output logic                    done
);
    localparam int NCFG = 4 * NPINS;
    localparam int CIW  = $clog2(NCFG);
    localparam int CNTW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUIESCE = 3'd1,
        S_APPLY   = 3'd2,
        S_WAIT    = 3'd3,
        S_RELEASE = 3'd4
    } state_t;

    state_t                  r_state;
    state_t                  w_next;

    logic [NPINS-1:0]        r_sh_ie  [4];
    logic [NPINS-1:0]        r_sh_oen [4];
    logic [CFGW-1:0]         r_sh_cfg [NCFG];

    logic [4*NPINS-1:0]      r_pad_ie;
    logic [4*NPINS-1:0]      r_pad_oen;
    logic [4*NPINS*CFGW-1:0] r_pad_cfg;
    logic [1:0]              r_side;
    logic [CNTW-1:0]         r_cnt;
    logic [15:0]             r_commit_cnt;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_rvalid;
    logic [31:0]             r_rdata;

    logic                    w_acc;
    logic                    w_wr;
    logic                    w_rd;
    logic                    w_is_ie;
    logic                    w_is_oen;
    logic                    w_is_cfg;
    logic                    w_is_ctrl;
    logic                    w_is_stat;
    logic                    w_commit;
    logic [31:0]             w_cfg_off;
    logic [CIW-1:0]          w_cfg_idx;
    logic [31:0]             w_rd_val;
    logic                    w_quiesce;
    logic                    w_apply;
    logic                    w_release;
    logic                    w_last_side;
    logic                    w_unused;

    // Writes stall during a commit so the shadows stay frozen; reads never stall.
    assign bus.reg_ready = !(r_busy && bus.reg_write);
    assign w_acc         = bus.reg_valid && bus.reg_ready;
    assign w_wr          = w_acc && bus.reg_write;
    assign w_rd          = w_acc && !bus.reg_write;

    assign w_is_ie   = (bus.reg_addr[7:2] == 6'd0);
    assign w_is_oen  = (bus.reg_addr[7:2] == 6'd1);
    assign w_is_ctrl = (bus.reg_addr == 8'h40);
    assign w_is_stat = (bus.reg_addr == 8'h41);
    assign w_cfg_off = 32'(bus.reg_addr) - 32'h10;
    assign w_is_cfg  = (bus.reg_addr >= 8'h10) && (w_cfg_off < NCFG) && !w_is_ctrl && !w_is_stat;
    assign w_cfg_idx = w_cfg_off[CIW-1:0];
    assign w_commit  = w_wr && w_is_ctrl && bus.reg_wdata[0] && (r_state == S_IDLE);

    assign w_last_side = (r_side == 2'd3);
    assign w_unused    = ^{bus.reg_wdata, w_cfg_off};

    always_comb begin
        w_rd_val = '0;
        if (w_is_ie) begin
            w_rd_val[NPINS-1:0] = r_sh_ie[bus.reg_addr[1:0]];
        end else if (w_is_oen) begin
            w_rd_val[NPINS-1:0] = r_sh_oen[bus.reg_addr[1:0]];
        end else if (w_is_cfg) begin
            w_rd_val[CFGW-1:0] = r_sh_cfg[w_cfg_idx];
        end else if (w_is_ctrl) begin
            w_rd_val = {28'b0, r_side, 1'b0, r_busy};
        end else if (w_is_stat) begin
            w_rd_val = {16'b0, r_commit_cnt};
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            for (int s = 0; s < 4; s++) begin
                r_sh_ie[s]  <= '0;
                r_sh_oen[s] <= '1;
            end
            for (int i = 0; i < NCFG; i++) begin
                r_sh_cfg[i] <= '0;
            end
        end else if (w_wr) begin
            if (w_is_ie) begin
                r_sh_ie[bus.reg_addr[1:0]] <= bus.reg_wdata[NPINS-1:0];
            end else if (w_is_oen) begin
                r_sh_oen[bus.reg_addr[1:0]] <= bus.reg_wdata[NPINS-1:0];
            end else if (w_is_cfg) begin
                r_sh_cfg[w_cfg_idx] <= bus.reg_wdata[CFGW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_rvalid <= w_rd;
            if (w_rd) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_commit) w_next = S_QUIESCE;
            S_QUIESCE: w_next = S_APPLY;
            S_APPLY:   w_next = S_WAIT;
            S_WAIT:    if (r_cnt == '0) w_next = S_RELEASE;
            S_RELEASE: w_next = w_last_side ? S_IDLE : S_QUIESCE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_quiesce = 1'b0;
        w_apply   = 1'b0;
        w_release = 1'b0;
        case (r_state)
            S_QUIESCE: w_quiesce = 1'b1;
            S_APPLY:   w_apply   = 1'b1;
            S_RELEASE: w_release = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_pad_ie     <= '0;
            r_pad_oen    <= '1;
            r_pad_cfg    <= '0;
            r_side       <= 2'd0;
            r_cnt        <= '0;
            r_commit_cnt <= 16'd0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_commit) begin
                r_busy <= 1'b1;
                r_side <= 2'd0;
            end
            if (w_apply) begin
                r_cnt <= CNTW'(SETTLE - 1);
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_release) begin
                if (w_last_side) begin
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_commit_cnt <= r_commit_cnt + 16'd1;
                end else begin
                    r_side <= r_side + 2'd1;
                end
            end
            // Only the side in sequence is touched; the others hold their last values.
            for (int s = 0; s < 4; s++) begin
                if (r_side == 2'(s)) begin
                    if (w_quiesce) begin
                        r_pad_ie[s*NPINS +: NPINS]  <= '0;
                        r_pad_oen[s*NPINS +: NPINS] <= '1;
                    end
                    if (w_apply) begin
                        for (int p = 0; p < NPINS; p++) begin
                            r_pad_cfg[(s*NPINS+p)*CFGW +: CFGW] <= r_sh_cfg[s*NPINS+p];
                        end
                    end
                    if (w_release) begin
                        r_pad_ie[s*NPINS +: NPINS]  <= r_sh_ie[s];
                        r_pad_oen[s*NPINS +: NPINS] <= r_sh_oen[s];
                    end
                end
            end
        end
    end

    assign pad_ie         = r_pad_ie;
    assign pad_oen        = r_pad_oen;
    assign pad_cfg        = r_pad_cfg;
    assign busy           = r_busy;
    assign done           = r_done;
    assign bus.reg_rvalid = r_rvalid;
    assign bus.reg_rdata  = r_rdata;
endmodule

// File: tb/tb_pad_cfg_sequencer.sv
// Bench for pad_cfg_sequencer: randomized register traffic against a register-map model,
// read data checked by a scoreboard monitor, pad sequencing checked by glitch/timing monitors.
module tb_pad_cfg_sequencer;
    localparam int NPINS    = 9;
    localparam int CFGW     = 18;
    localparam int SETTLE   = 16;
    localparam int NCFG     = 4 * NPINS;
    localparam int BUSY_LEN = 4 * (3 + SETTLE);

    logic clk = 1'b0;
    logic nreset = 1'b1;
    always #5 clk = ~clk;

    pad_cfg_sequencer_if bus();
    logic [4*NPINS-1:0]      pad_ie;
    logic [4*NPINS-1:0]      pad_oen;
    logic [4*NPINS*CFGW-1:0] pad_cfg;
    logic                    busy;
    logic                    done;

    pad_cfg_sequencer #(.NPINS(NPINS), .CFGW(CFGW), .SETTLE(SETTLE)) dut (
        .clk     (clk),
        .nreset  (nreset),
        .bus     (bus),
        .pad_ie  (pad_ie),
        .pad_oen (pad_oen),
        .pad_cfg (pad_cfg),
        .busy    (busy),
        .done    (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: shadow registers, pad outputs and status as the register map defines them.
    logic [NPINS-1:0] m_ie [4];
    logic [NPINS-1:0] m_oen [4];
    logic [CFGW-1:0]  m_cfg [NCFG];
    logic [NPINS-1:0] m_pie [4];
    logic [NPINS-1:0] m_poen [4];
    logic [CFGW-1:0]  m_pcfg [NCFG];
    logic [15:0]      m_cnt;
    logic [1:0]       m_side;
    int               commits_total = 0;

    task automatic model_reset();
        for (int s = 0; s < 4; s++) begin
            m_ie[s] = '0; m_oen[s] = '1; m_pie[s] = '0; m_poen[s] = '1;
        end
        for (int i = 0; i < NCFG; i++) begin
            m_cfg[i] = '0; m_pcfg[i] = '0;
        end
        m_cnt = 16'd0;
        m_side = 2'd0;
    endtask

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        int idx;
        idx = int'(a) - 16;
        if (a < 8'h04) m_ie[a[1:0]] = d[NPINS-1:0];
        else if (a < 8'h08) m_oen[a[1:0]] = d[NPINS-1:0];
        else if (a >= 8'h10 && idx < NCFG) m_cfg[idx] = d[CFGW-1:0];
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int idx;
        idx = int'(a) - 16;
        if (a < 8'h04) return 32'(m_ie[a[1:0]]);
        if (a < 8'h08) return 32'(m_oen[a[1:0]]);
        if (a >= 8'h10 && idx < NCFG) return 32'(m_cfg[idx]);
        if (a == 8'h40) return {28'b0, m_side, 2'b00};
        if (a == 8'h41) return {16'b0, m_cnt};
        return 32'h0;
    endfunction

    task automatic model_commit();
        for (int s = 0; s < 4; s++) begin
            m_pie[s] = m_ie[s];
            m_poen[s] = m_oen[s];
        end
        for (int i = 0; i < NCFG; i++) m_pcfg[i] = m_cfg[i];
        m_cnt = m_cnt + 16'd1;
        m_side = 2'd3;
        commits_total++;
    endtask

    task automatic check_pads();
        for (int s = 0; s < 4; s++) begin
            check($sformatf("pad_ie_s%0d", s), 64'(pad_ie[s*NPINS +: NPINS]), 64'(m_pie[s]));
            check($sformatf("pad_oen_s%0d", s), 64'(pad_oen[s*NPINS +: NPINS]), 64'(m_poen[s]));
        end
        for (int i = 0; i < NCFG; i++) begin
            check($sformatf("pad_cfg_%0d", i), 64'(pad_cfg[i*CFGW +: CFGW]), 64'(m_pcfg[i]));
        end
    endtask

    logic [31:0] exp_q[$];

    task automatic bus_xfer(input logic wr, input logic [7:0] a, input logic [31:0] d, output int stalls);
        logic accepted;
        stalls = 0;
        accepted = 1'b0;
        @(negedge clk);
        bus.reg_valid = 1'b1;
        bus.reg_write = wr;
        bus.reg_addr  = a;
        bus.reg_wdata = d;
        while (!accepted && stalls < 2000) begin
            @(posedge clk);
            if (bus.reg_ready) accepted = 1'b1;
            else stalls++;
        end
        if (!accepted) check("bus_accept_timeout", 64'(accepted), 64'(1));
        else if (wr) model_write(a, d);
        else exp_q.push_back(model_read(a));
        #1;
        bus.reg_valid = 1'b0;
        bus.reg_write = 1'b0;
    endtask

    function automatic logic [7:0] rand_addr();
        case ($urandom_range(0, 2))
            0:       return 8'($urandom_range(0, 3));
            1:       return 8'(4 + $urandom_range(0, 3));
            default: return 8'(16 + $urandom_range(0, NCFG - 1));
        endcase
    endfunction

    logic [NPINS-1:0] oen_trace[$];

    task automatic do_commit();
        int st;
        int k;
        logic [NPINS-1:0] last;
        bus_xfer(1'b1, 8'h40, 32'h1, st);
        oen_trace.delete();
        last = pad_oen[NPINS-1:0];
        k = 0;
        while (k < 400 && done !== 1'b1) begin
            @(negedge clk);
            k++;
            if (pad_oen[NPINS-1:0] !== last) begin
                last = pad_oen[NPINS-1:0];
                oen_trace.push_back(last);
            end
        end
        check("commit_done_seen", 64'(done), 64'(1));
        model_commit();
        check_pads();
    endtask

    // Scoreboard monitor: every read response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (nreset && bus.reg_rvalid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rdata_unexpected: got 0x%0h, expected no response", bus.reg_rdata);
            end else begin
                check("rdata", 64'(bus.reg_rdata), 64'(exp_q.pop_front()));
            end
        end
    end

    int done_total = 0;
    int blen = 0;
    always @(negedge clk) begin
        if (!nreset) begin
            blen = 0;
        end else begin
            if (done) done_total++;
            if (busy) blen++;
            else if (blen != 0) begin
                check("busy_len", 64'(blen), 64'(BUSY_LEN));
                blen = 0;
            end
        end
    end

    // Glitch monitor: config may change only on a quiesced side; ie/oen must pass through off.
    logic [4*NPINS-1:0]      prev_ie;
    logic [4*NPINS-1:0]      prev_oen;
    logic [4*NPINS*CFGW-1:0] prev_cfg;
    logic                    nreset_q = 1'b0;
    always @(negedge clk) begin
        if (nreset && nreset_q) begin
            for (int s = 0; s < 4; s++) begin
                logic [NPINS-1:0] po, co, pi, ci;
                po = prev_oen[s*NPINS +: NPINS];
                co = pad_oen[s*NPINS +: NPINS];
                pi = prev_ie[s*NPINS +: NPINS];
                ci = pad_ie[s*NPINS +: NPINS];
                if (pad_cfg[s*NPINS*CFGW +: NPINS*CFGW] !== prev_cfg[s*NPINS*CFGW +: NPINS*CFGW])
                    check($sformatf("cfg_change_quiesced_s%0d", s), 64'({&po, |pi, &co, |ci}), 64'(4'b1010));
                if (co !== po)
                    check($sformatf("oen_via_all_ones_s%0d", s), 64'((&po) || (&co)), 64'(1));
                if (ci !== pi)
                    check($sformatf("ie_via_zero_s%0d", s), 64'((pi == '0) || (ci == '0)), 64'(1));
            end
        end
        prev_ie  = pad_ie;
        prev_oen = pad_oen;
        prev_cfg = pad_cfg;
        nreset_q = nreset;
    end

    initial begin
        int st;
        int cfg_k, ie_k, done_k;
        bus.reg_valid = 1'b0;
        bus.reg_write = 1'b0;
        bus.reg_addr  = 8'h00;
        bus.reg_wdata = 32'h0;
        model_reset();
        #1 nreset = 1'b0;
        #1;
        check("rst_pad_ie", 64'(pad_ie), 64'(0));
        check("rst_pad_oen", 64'(pad_oen), 64'({4*NPINS{1'b1}}));
        check("rst_pad_cfg_zero", 64'(pad_cfg == '0), 64'(1));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_ready", 64'(bus.reg_ready), 64'(1));
        check("rst_rvalid", 64'(bus.reg_rvalid), 64'(0));
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        bus_xfer(1'b0, 8'h41, 32'h0, st);

        // Directed single commit with edge-accurate timing on the north side.
        bus_xfer(1'b1, 8'h00, 32'h1FF, st);
        bus_xfer(1'b1, 8'h04, 32'h000, st);
        bus_xfer(1'b1, 8'h10, 32'h2AAAA, st);
        bus_xfer(1'b1, 8'h40, 32'h1, st);
        cfg_k = 0; ie_k = 0; done_k = 0;
        for (int k = 1; k <= 200 && done_k == 0; k++) begin
            @(negedge clk);
            if (cfg_k == 0 && pad_cfg[CFGW-1:0] == 18'h2AAAA) cfg_k = k;
            if (ie_k == 0 && pad_ie[NPINS-1:0] == 9'h1FF) ie_k = k;
            if (done) done_k = k;
        end
        check("north_cfg_apply_cycle", 64'(cfg_k), 64'(3));
        check("north_ie_release_cycle", 64'(ie_k), 64'(3 + SETTLE + 1));
        check("done_cycle", 64'(done_k), 64'(BUSY_LEN + 1));
        @(negedge clk);
        check("done_single_pulse", 64'(done), 64'(0));
        model_commit();
        check_pads();
        bus_xfer(1'b0, 8'h41, 32'h0, st);

        // North oen 0x000 -> 0x0FF must pass through all-ones.
        bus_xfer(1'b1, 8'h04, 32'h0FF, st);
        do_commit();
        check("oen_trace_len", 64'(oen_trace.size()), 64'(2));
        if (oen_trace.size() == 2) begin
            check("oen_trace_0", 64'(oen_trace[0]), 64'(9'h1FF));
            check("oen_trace_1", 64'(oen_trace[1]), 64'(9'h0FF));
        end

        // A write issued during a commit stalls until the commit has finished.
        bus_xfer(1'b1, 8'h40, 32'h1, st);
        model_commit();
        bus_xfer(1'b1, 8'h01, 32'h055, st);
        check("stall_cycles", 64'(st), 64'(BUSY_LEN));
        check_pads();
        do_commit();
        check("east_ie", 64'(pad_ie[NPINS +: NPINS]), 64'(9'h055));

        // Randomized shadow traffic and commits.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 8);
            for (int w = 0; w < nw; w++) bus_xfer(1'b1, rand_addr(), $urandom(), st);
            for (int q = 0; q < 3; q++) bus_xfer(1'b0, rand_addr(), 32'h0, st);
            if (r == 3) begin
                bus_xfer(1'b1, 8'h40, 32'hFFFF_FFFE, st);
                repeat (3) @(negedge clk);
                check("ctrl_bit0_zero_no_busy", 64'(busy), 64'(0));
                check_pads();
            end
            do_commit();
            bus_xfer(1'b0, 8'h40, 32'h0, st);
        end

        // Reset during side 2's settle wait.
        for (int s = 0; s < 4; s++) bus_xfer(1'b1, 8'(s), $urandom(), st);
        bus_xfer(1'b0, 8'h41, 32'h0, st);
        bus_xfer(1'b1, 8'h40, 32'h1, st);
        repeat (2 * (3 + SETTLE) + 8) @(negedge clk);
        check("busy_before_reset", 64'(busy), 64'(1));
        #1 nreset = 1'b0;
        #1;
        check("arst_pad_ie", 64'(pad_ie), 64'(0));
        check("arst_pad_oen", 64'(pad_oen), 64'({4*NPINS{1'b1}}));
        check("arst_pad_cfg_zero", 64'(pad_cfg == '0), 64'(1));
        check("arst_busy", 64'(busy), 64'(0));
        check("arst_rvalid", 64'(bus.reg_rvalid), 64'(0));
        check("arst_rdata", 64'(bus.reg_rdata), 64'(0));
        model_reset();
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        bus_xfer(1'b0, 8'h41, 32'h0, st);
        bus_xfer(1'b0, 8'h40, 32'h0, st);
        bus_xfer(1'b0, 8'h02, 32'h0, st);
        bus_xfer(1'b0, 8'h06, 32'h0, st);
        bus_xfer(1'b0, 8'h10, 32'h0, st);
        check_pads();

        // Commit counter wraps from 0xFFFF to 0.
        @(negedge clk);
        force dut.r_commit_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.r_commit_cnt;
        m_cnt = 16'hFFFF;
        bus_xfer(1'b0, 8'h41, 32'h0, st);
        bus_xfer(1'b1, 8'h20, $urandom(), st);
        do_commit();
        bus_xfer(1'b0, 8'h41, 32'h0, st);

        // Unmapped write has no effect; full-map sweep against the model.
        bus_xfer(1'b1, 8'h7F, $urandom(), st);
        bus_xfer(1'b1, 8'h08, $urandom(), st);
        for (int a = 0; a < 128; a++) bus_xfer(1'b0, 8'(a), 32'h0, st);
        check_pads();

        repeat (4) @(negedge clk);
        check("read_queue_drained", 64'(exp_q.size()), 64'(0));
        check("done_pulse_total", 64'(done_total), 64'(commits_total));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
